// File: rtl/mem_pilo_1p_32x32_drain_pkg.sv
// Shared definitions for the block-write / line-read reconstruction buffer.
package mem_pilo_1p_32x32_drain_pkg;

  localparam int unsigned NUM_ROWS   = 32;
  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  // Block size codes on w_size_i
  localparam logic [1:0] I_4x4   = 2'b00;
  localparam logic [1:0] I_8x8   = 2'b01;
  localparam logic [1:0] I_16x16 = 2'b10;
  localparam logic [1:0] I_32x32 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StDone
  } drain_state_e;

  // Bank holding 8-pixel chunk `chunk` of row `row`; the row-based swizzle keeps every
  // write shape and every full-line read spread over four distinct banks.
  function automatic logic [1:0] bank_of(input logic [1:0] chunk, input logic [4:0] row);
    return chunk ^ {row[0], row[1]};
  endfunction

endpackage

// File: rtl/mem_pilo_1p_32x32_drain_ram.sv
// Single-port 64 x 8-pixel RAM with a per-half-word write mask and 1-cycle read latency.
module buf_ram_1p_64x64_hm #(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [5:0]               addr_i,
  input  logic [1:0]               wmask_i,   // [1] upper 4 pixels, [0] lower 4 pixels
  input  logic [PIXEL_WIDTH*8-1:0] wdata_i,
  output logic [PIXEL_WIDTH*8-1:0] rdata_o
);

  localparam int unsigned W = PIXEL_WIDTH * 8;
  localparam int unsigned H = PIXEL_WIDTH * 4;

  logic [W-1:0] mem_q [64];
  logic [W-1:0] rdata_q;

  // Write has priority; a read only updates the output register when not writing.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (wmask_i[1]) mem_q[addr_i][W-1:H] <= wdata_i[W-1:H];
      if (wmask_i[0]) mem_q[addr_i][H-1:0] <= wdata_i[H-1:0];
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_pilo_1p_32x32_drain.sv
// Block-write, line-read buffer: block rows in, whole 32-pixel lines out via valid/ready.
module mem_pilo_1p_32x32_drain
  import mem_pilo_1p_32x32_drain_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // block write side
  input  logic                      w_en_i,
  input  logic                      w_sel_i,
  input  logic [1:0]                w_size_i,
  input  logic [2:0]                w_4x4_x_i,
  input  logic [2:0]                w_4x4_y_i,
  input  logic [4:0]                w_idx_i,
  input  logic [PIXEL_WIDTH*32-1:0] w_data_i,
  // drain control
  input  logic                      drain_start_i,
  input  logic                      drain_sel_i,
  input  logic [5:0]                drain_rows_i,
  output logic                      drain_busy_o,
  output logic                      drain_done_o,
  // line output
  output logic                      l_valid_o,
  input  logic                      l_ready_i,
  output logic [PIXEL_WIDTH*32-1:0] l_data_o,
  output logic [4:0]                l_row_o,
  output logic                      l_last_o
);

  localparam int unsigned CW = PIXEL_WIDTH * 8;   // chunk width
  localparam int unsigned HW = PIXEL_WIDTH * 4;   // half-chunk width
  localparam int unsigned LW = PIXEL_WIDTH * 32;  // line width

  drain_state_e state_q, state_d;
  logic         sel_q, sel_d;
  logic [5:0]   rows_q, rows_d;
  logic [5:0]   row_cnt_q, row_cnt_d;

  logic         rd_vld_q;
  logic [4:0]   rd_row_q;
  logic         rd_last_q;

  logic [1:0]    fifo_cnt_q;
  logic [LW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [4:0]    fifo_row_q  [FIFO_DEPTH];
  logic          fifo_last_q [FIFO_DEPTH];

  logic [4:0]    slot_row   [NUM_BANKS];
  logic [1:0]    slot_chunk [NUM_BANKS];
  logic [CW-1:0] slot_data  [NUM_BANKS];
  logic [1:0]    wr_mask;

  logic [5:0]    bank_addr  [NUM_BANKS];
  logic [CW-1:0] bank_wdata [NUM_BANKS];
  logic [1:0]    bank_wmask [NUM_BANKS];
  logic [CW-1:0] bank_rdata [NUM_BANKS];

  logic [LW-1:0] rd_line;
  logic          pop, push, credit_ok, rd_issue, rd_is_last;
  logic [5:0]    rows_clamped;

  assign l_valid_o    = (fifo_cnt_q != 2'd0);
  assign l_data_o     = fifo_data_q[0];
  assign l_row_o      = fifo_row_q[0];
  assign l_last_o     = fifo_last_q[0];
  assign drain_busy_o = (state_q != StIdle);
  assign drain_done_o = (state_q == StDone);

  assign pop  = l_valid_o & l_ready_i;
  assign push = rd_vld_q;
  // Counting this cycle's pop keeps one line per cycle while never overfilling the FIFO.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {2'b00, rd_vld_q}) < (3'(FIFO_DEPTH) + {2'b00, pop});
  assign rd_issue  = (state_q == StRead) && !w_en_i && credit_ok;
  assign rd_is_last   = (row_cnt_q == rows_q - 6'd1);
  assign rows_clamped = (drain_rows_i > 6'(NUM_ROWS)) ? 6'(NUM_ROWS) : drain_rows_i;

  // Map the incoming block row group onto four (row, chunk) slots, slot s = data chunk s.
  always_comb begin
    wr_mask = (w_size_i == I_4x4) ? (w_4x4_x_i[0] ? 2'b01 : 2'b10) : 2'b11;
    for (int s = 0; s < NUM_BANKS; s++) begin
      slot_row[s]   = '0;
      slot_chunk[s] = '0;
      slot_data[s]  = w_data_i[LW-1-s*CW -: CW];
      unique case (w_size_i)
        I_4x4: begin
          slot_row[s]   = {w_4x4_y_i, s[1:0]};
          slot_chunk[s] = w_4x4_x_i[2:1];
          // Both halves carry the 4 pixels; the mask picks the half that is written.
          slot_data[s]  = {2{w_data_i[LW-1-s*HW -: HW]}};
        end
        I_8x8: begin
          slot_row[s]   = {w_4x4_y_i[2:1], w_idx_i[0], s[1:0]};
          slot_chunk[s] = w_4x4_x_i[2:1];
        end
        I_16x16: begin
          slot_row[s]   = {w_4x4_y_i[2], w_idx_i[2:0], s[1]};
          slot_chunk[s] = {w_4x4_x_i[2], s[0]};
        end
        I_32x32: begin
          slot_row[s]   = w_idx_i;
          slot_chunk[s] = s[1:0];
        end
      endcase
    end
  end

  // Steer slots to their banks on writes; otherwise all banks address the drain row.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_addr[b]  = {sel_q, row_cnt_q[4:0]};
      bank_wdata[b] = '0;
      bank_wmask[b] = '0;
      if (w_en_i) begin
        for (int s = 0; s < NUM_BANKS; s++) begin
          if (bank_of(slot_chunk[s], slot_row[s]) == 2'(b)) begin
            bank_addr[b]  = {w_sel_i, slot_row[s]};
            bank_wdata[b] = slot_data[s];
            bank_wmask[b] = wr_mask;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    buf_ram_1p_64x64_hm #(
      .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_bank (
      .clk    (clk),
      .we_i   (w_en_i),
      .re_i   (rd_issue),
      .addr_i (bank_addr[g]),
      .wmask_i(bank_wmask[g]),
      .wdata_i(bank_wdata[g]),
      .rdata_o(bank_rdata[g])
    );
  end

  // Un-swizzle the registered read into chunk0..chunk3, MSB first.
  always_comb begin
    rd_line = '0;
    for (int c = 0; c < NUM_BANKS; c++) begin
      rd_line[LW-1-c*CW -: CW] = bank_rdata[bank_of(2'(c), rd_row_q)];
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rows_d    = rows_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      StIdle: begin
        if (drain_start_i) begin
          sel_d     = drain_sel_i;
          rows_d    = rows_clamped;
          row_cnt_d = '0;
          state_d   = (rows_clamped == 6'd0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (rd_issue) begin
          row_cnt_d = row_cnt_q + 6'd1;
          if (rd_is_last) state_d = StFlush;
        end
      end
      StFlush: begin
        // Leave as the final line is accepted so done lands in the following cycle.
        if (!rd_vld_q && (fifo_cnt_q == 2'd0 || (fifo_cnt_q == 2'd1 && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and read-pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= 1'b0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_row_q  <= '0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rows_q    <= rows_d;
      row_cnt_q <= row_cnt_d;
      rd_vld_q  <= rd_issue;
      if (rd_issue) begin
        rd_row_q  <= row_cnt_q[4:0];
        rd_last_q <= rd_is_last;
      end
    end
  end

  // Two-entry output skid FIFO; entry 0 is the head driving the line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_row_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            fifo_data_q[0] <= rd_line;
            fifo_row_q[0]  <= rd_row_q;
            fifo_last_q[0] <= rd_last_q;
          end else begin
            fifo_data_q[1] <= rd_line;
            fifo_row_q[1]  <= rd_row_q;
            fifo_last_q[1] <= rd_last_q;
          end
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo_data_q[0] <= fifo_data_q[1];
          fifo_row_q[0]  <= fifo_row_q[1];
          fifo_last_q[0] <= fifo_last_q[1];
          fifo_cnt_q     <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo_data_q[0] <= rd_line;
            fifo_row_q[0]  <= rd_row_q;
            fifo_last_q[0] <= rd_last_q;
          end else begin
            fifo_data_q[0] <= fifo_data_q[1];
            fifo_row_q[0]  <= fifo_row_q[1];
            fifo_last_q[0] <= fifo_last_q[1];
            fifo_data_q[1] <= rd_line;
            fifo_row_q[1]  <= rd_row_q;
            fifo_last_q[1] <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
